// File: rtl/psg_tone_bank.sv
// psg_tone_bank: NUM_CH programmable square-wave tone channels feeding a registered volume mixer.
// Define PSG_TONE_BANK_NOISE_EN to add a 17-bit LFSR noise source that gates the mixer.
module psg_tone_bank #(
  parameter int  NUM_CH   = 3,
  parameter int  PERIOD_W = 12,
  parameter int  VOL_W    = 4,
  parameter int  PRESCALE = 16,
  localparam int MIX_W    = VOL_W + $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wr_en,
  input  logic [5:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [NUM_CH-1:0] tone_out,
  output logic [MIX_W-1:0]  mix_out,
  output logic              tick
);
  localparam int         PRE_W     = $clog2(PRESCALE);
  localparam logic [5:0] ADDR_MASK = 6'(3*NUM_CH);

  logic [PRE_W-1:0]    r_pre;
  logic [PERIOD_W-1:0] r_period [NUM_CH];
  logic [VOL_W-1:0]    r_vol    [NUM_CH];
  logic [PERIOD_W-1:0] r_cnt    [NUM_CH];
  logic [NUM_CH-1:0]   r_mask;
  logic [NUM_CH-1:0]   r_tone;
  logic [MIX_W-1:0]    r_mix;

  logic                w_tick;
  logic [PERIOD_W:0]   w_next   [NUM_CH];
  logic [PERIOD_W-1:0] w_lim    [NUM_CH];
  logic [NUM_CH-1:0]   w_gate;
  logic [MIX_W-1:0]    w_sum;

  assign w_tick   = ena && (r_pre == PRE_W'(PRESCALE-1));
  assign tick     = w_tick;
  assign tone_out = r_tone;
  assign mix_out  = r_mix;

  // NOTE: state registers use non-blocking (<=); blocking is only for combinational temporaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_pre <= '0;
    else if (ena) r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
  end

  // NOTE: register arrays are cleared by an explicit loop so every entry reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_period[c] <= '0;
        r_vol[c]    <= '0;
      end
    end else if (wr_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_addr == 6'(2*c))        r_period[c][7:0]          <= wr_data;
        if (wr_addr == 6'(2*c+1))      r_period[c][PERIOD_W-1:8] <= wr_data[PERIOD_W-9:0];
        if (wr_addr == 6'(2*NUM_CH+c)) r_vol[c]                  <= wr_data[VOL_W-1:0];
      end
      if (wr_addr == ADDR_MASK) r_mask <= wr_data[NUM_CH-1:0];
    end
  end

  // Comparing against the limit with >= makes a period lowered below cnt expire on the next tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tone <= '0;
      for (int c = 0; c < NUM_CH; c++) r_cnt[c] <= '0;
    end else if (w_tick) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_next[c] >= {1'b0, w_lim[c]}) begin
          r_cnt[c]  <= '0;
          r_tone[c] <= ~r_tone[c];
        end else begin
          r_cnt[c]  <= w_next[c][PERIOD_W-1:0];
        end
      end
    end
  end

`ifdef PSG_TONE_BANK_NOISE_EN
  localparam logic [5:0] ADDR_NPER  = 6'(3*NUM_CH+1);
  localparam logic [5:0] ADDR_NMASK = 6'(3*NUM_CH+2);

  logic [4:0]        r_nper;
  logic [4:0]        r_ncnt;
  logic [NUM_CH-1:0] r_nmask;
  logic [16:0]       r_lfsr;
  logic [5:0]        w_nnext;
  logic [4:0]        w_nlim;

  assign w_nnext = {1'b0, r_ncnt} + 6'd1;
  assign w_nlim  = (r_nper == 5'd0) ? 5'd1 : r_nper;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nper  <= '0;
      r_nmask <= '0;
    end else if (wr_en) begin
      if (wr_addr == ADDR_NPER)  r_nper  <= wr_data[4:0];
      if (wr_addr == ADDR_NMASK) r_nmask <= wr_data[NUM_CH-1:0];
    end
  end

  // Fibonacci LFSR, taps 17 and 14, advanced once per noise-counter expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ncnt <= '0;
      r_lfsr <= 17'd1;
    end else if (w_tick) begin
      if (w_nnext >= {1'b0, w_nlim}) begin
        r_ncnt <= '0;
        r_lfsr <= {r_lfsr[15:0], r_lfsr[16] ^ r_lfsr[13]};
      end else begin
        r_ncnt <= w_nnext[4:0];
      end
    end
  end

  assign w_gate = (r_tone | ~r_mask) & ({NUM_CH{r_lfsr[0]}} | ~r_nmask);
`else
  assign w_gate = r_tone & r_mask;
`endif

  // NOTE: every always_comb output gets a default before any conditional so no latch is inferred.
  always_comb begin
    w_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_next[c] = {1'b0, r_cnt[c]} + (PERIOD_W+1)'(1);
      w_lim[c]  = (r_period[c] == '0) ? PERIOD_W'(1) : r_period[c];
      if (w_gate[c]) w_sum = w_sum + MIX_W'(r_vol[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mix <= '0;
    else        r_mix <= w_sum;
  end

endmodule

// File: tb/tb_psg_tone_bank.sv
// Self-checking bench for psg_tone_bank: directed scenarios plus random traffic against a tick-level model.
module tb_psg_tone_bank;
  localparam int NUM_CH   = 3;
  localparam int PERIOD_W = 12;
  localparam int VOL_W    = 4;
  localparam int PRESCALE = 16;
  localparam int MIX_W    = VOL_W + $clog2(NUM_CH);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              wr_en;
  logic [5:0]        wr_addr;
  logic [7:0]        wr_data;
  logic [NUM_CH-1:0] tone_out;
  logic [MIX_W-1:0]  mix_out;
  logic              tick;

  int n_cmp = 0;
  int n_bad = 0;

  psg_tone_bank #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W), .VOL_W(VOL_W), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .tone_out(tone_out), .mix_out(mix_out), .tick(tick)
  );

  always #5 clk = ~clk;

  // Reference model: registers, per-channel tick counts since last toggle, tone levels.
  int m_pre, m_mask, m_mix;
  int m_per [NUM_CH];
  int m_vol [NUM_CH];
  int m_cnt [NUM_CH];
  int m_tone[NUM_CH];
  int m_nper, m_nmask, m_ncnt, m_lfsr;

  function automatic int model_mix();
    int s = 0;
    for (int c = 0; c < NUM_CH; c++) begin
`ifdef PSG_TONE_BANK_NOISE_EN
      if ((m_tone[c] == 1 || ((m_mask >> c) & 1) == 0) &&
          ((m_lfsr & 1) == 1 || ((m_nmask >> c) & 1) == 0)) s += m_vol[c];
`else
      if (m_tone[c] == 1 && ((m_mask >> c) & 1) == 1) s += m_vol[c];
`endif
    end
    return s;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_tone();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = (m_tone[c] != 0);
    return v;
  endfunction

  function automatic logic exp_tick();
    return (ena === 1'b1) && (m_pre == PRESCALE-1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pre <= 0; m_mask <= 0; m_mix <= 0;
      m_nper <= 0; m_nmask <= 0; m_ncnt <= 0; m_lfsr <= 1;
      for (int c = 0; c < NUM_CH; c++) begin
        m_per[c] <= 0; m_vol[c] <= 0; m_cnt[c] <= 0; m_tone[c] <= 0;
      end
    end else begin
      m_mix <= model_mix();
      if (ena) begin
        m_pre <= (m_pre + 1) % PRESCALE;
        if (m_pre == PRESCALE-1) begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (m_cnt[c] + 1 >= ((m_per[c] == 0) ? 1 : m_per[c])) begin
              m_cnt[c] <= 0; m_tone[c] <= 1 - m_tone[c];
            end else m_cnt[c] <= m_cnt[c] + 1;
          end
`ifdef PSG_TONE_BANK_NOISE_EN
          if (m_ncnt + 1 >= ((m_nper == 0) ? 1 : m_nper)) begin
            m_ncnt <= 0;
            m_lfsr <= ((m_lfsr << 1) | (((m_lfsr >> 16) ^ (m_lfsr >> 13)) & 1)) & 'h1FFFF;
          end else m_ncnt <= m_ncnt + 1;
`endif
        end
      end
      if (wr_en) begin
        if (int'(wr_addr) < 2*NUM_CH) begin
          if (wr_addr[0] == 1'b0)
            m_per[wr_addr/2] <= (m_per[wr_addr/2] / 256) * 256 + int'(wr_data);
          else
            m_per[wr_addr/2] <= (m_per[wr_addr/2] % 256) + (int'(wr_data) % (1 << (PERIOD_W-8))) * 256;
        end else if (int'(wr_addr) < 3*NUM_CH)
          m_vol[int'(wr_addr) - 2*NUM_CH] <= int'(wr_data) % (1 << VOL_W);
        else if (int'(wr_addr) == 3*NUM_CH)
          m_mask <= int'(wr_data) % (1 << NUM_CH);
`ifdef PSG_TONE_BANK_NOISE_EN
        else if (int'(wr_addr) == 3*NUM_CH+1) m_nper  <= int'(wr_data) % 32;
        else if (int'(wr_addr) == 3*NUM_CH+2) m_nmask <= int'(wr_data) % (1 << NUM_CH);
`endif
      end
    end
  end

  task automatic drive(input logic en, input logic we, input int a, input int d);
    @(negedge clk);
    ena = en; wr_en = we; wr_addr = 6'(a); wr_data = 8'(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ena = 1'b0; wr_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, i[0], $urandom_range(0, 12), $urandom_range(0, 255));
      #1;
      n_cmp++;
      if ({tone_out, mix_out, tick} !== '0) begin
        n_bad++;
        $display("FAIL reset_hold cyc=%0d: tone=%b mix=%0d tick=%b, expected all 0", i, tone_out, mix_out, tick);
      end
    end
    @(negedge clk);
    wr_en = 1'b0; ena = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_period1();
    int last = -1, toggles = 0;
    logic prev;
    do_reset();
    drive(1'b0, 1'b1, 0, 1); drive(1'b0, 1'b1, 1, 0);
    drive(1'b0, 1'b1, 6, 5); drive(1'b0, 1'b1, 3*NUM_CH, 1);
    prev = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) drive(1'b1, 1'b1, 0, 0);
      else          drive(1'b1, 1'b0, 0, 0);
      #1;
      n_cmp++;
      if ({tone_out, mix_out, tick} !== {exp_tone(), MIX_W'(m_mix), exp_tick()}) begin
        n_bad++;
        $display("FAIL period1 cyc=%0d: tone=%b mix=%0d tick=%b, expected tone=%b mix=%0d tick=%b",
                 i, tone_out, mix_out, tick, exp_tone(), m_mix, exp_tick());
      end
      if (tone_out[0] !== prev) begin
        if (last >= 0) begin
          n_cmp++;
          if (i - last != 16) begin
            n_bad++;
            $display("FAIL period1_interval cyc=%0d: interval=%0d, expected 16", i, i - last);
          end
        end
        last = i; toggles++;
        prev = tone_out[0];
      end
    end
    n_cmp++;
    if (toggles < 20) begin
      n_bad++;
      $display("FAIL period1_toggles: saw %0d toggles, expected at least 20", toggles);
    end
  endtask

  task automatic test_ch1_period5();
    int last = -1;
    logic prev;
    do_reset();
    drive(1'b0, 1'b1, 2, 5); drive(1'b0, 1'b1, 2*NUM_CH+1, 9); drive(1'b0, 1'b1, 3*NUM_CH, 2);
    prev = 1'b0;
    for (int i = 0; i < 500; i++) begin
      drive(1'b1, 1'b0, 0, 0);
      #1;
      n_cmp++;
      if ({tone_out, mix_out, tick} !== {exp_tone(), MIX_W'(m_mix), exp_tick()}) begin
        n_bad++;
        $display("FAIL ch1_period5 cyc=%0d: tone=%b mix=%0d tick=%b, expected tone=%b mix=%0d tick=%b",
                 i, tone_out, mix_out, tick, exp_tone(), m_mix, exp_tick());
      end
      if (tone_out[1] !== prev) begin
        if (last >= 0) begin
          n_cmp++;
          if (i - last != 80) begin
            n_bad++;
            $display("FAIL ch1_interval cyc=%0d: interval=%0d, expected 80", i, i - last);
          end
        end
        last = i;
        prev = tone_out[1];
      end
    end
  endtask

  task automatic test_full_mix_freeze();
    int mx = 0;
    do_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      drive(1'b0, 1'b1, 2*c, 1); drive(1'b0, 1'b1, 2*NUM_CH+c, 15);
    end
    drive(1'b0, 1'b1, 3*NUM_CH, 7);
    for (int i = 0; i < 200; i++) begin
      drive(i < 100, 1'b0, 0, 0);
      #1;
      n_cmp++;
      if ({tone_out, mix_out, tick} !== {exp_tone(), MIX_W'(m_mix), exp_tick()}) begin
        n_bad++;
        $display("FAIL full_mix cyc=%0d: tone=%b mix=%0d tick=%b, expected tone=%b mix=%0d tick=%b",
                 i, tone_out, mix_out, tick, exp_tone(), m_mix, exp_tick());
      end
      if (int'(mix_out) > mx) mx = int'(mix_out);
      if (i >= 100) begin
        n_cmp++;
        if (tick !== 1'b0) begin
          n_bad++;
          $display("FAIL freeze_tick cyc=%0d: tick=%b, expected 0", i, tick);
        end
      end
    end
    n_cmp++;
    if (mx != 45) begin
      n_bad++;
      $display("FAIL full_mix_peak: peak=%0d, expected 45", mx);
    end
  endtask

  task automatic test_period_lower();
    logic exp_t;
    bit found = 0;
    do_reset();
    drive(1'b0, 1'b1, 0, 'hFF); drive(1'b0, 1'b1, 1, 0);
    for (int i = 0; i < 5000 && !found; i++) begin
      drive(1'b1, 1'b0, 0, 0);
      #1;
      if (m_cnt[0] == 200 && m_pre == PRESCALE-2) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL period_lower_reach: cnt 200 not reached within budget, expected reached");
    end else begin
      exp_t = (m_tone[0] != 0);
      drive(1'b1, 1'b1, 0, 'h10);
      #1;
      drive(1'b1, 1'b0, 0, 0);
      #1;
      n_cmp++;
      if (tone_out[0] !== exp_t) begin
        n_bad++;
        $display("FAIL write_on_tick: tone0=%b, expected %b (old period)", tone_out[0], exp_t);
      end
      for (int i = 0; i < 16; i++) begin
        drive(1'b1, 1'b0, 0, 0);
        #1;
        n_cmp++;
        if ({tone_out, mix_out, tick} !== {exp_tone(), MIX_W'(m_mix), exp_tick()}) begin
          n_bad++;
          $display("FAIL period_lower cyc=%0d: tone=%b mix=%0d tick=%b, expected tone=%b mix=%0d tick=%b",
                   i, tone_out, mix_out, tick, exp_tone(), m_mix, exp_tick());
        end
      end
      n_cmp++;
      if (tone_out[0] !== ~exp_t) begin
        n_bad++;
        $display("FAIL lowered_toggle: tone0=%b, expected %b", tone_out[0], ~exp_t);
      end
    end
  endtask

  task automatic test_random();
    int a, d;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 3*NUM_CH+3);
      d = $urandom_range(0, 255);
      if (a < 2*NUM_CH && a % 2 == 1) d = ($urandom_range(0, 7) == 0) ? d : 0;
      else if (a < 2*NUM_CH && $urandom_range(0, 1) == 1) d = $urandom_range(0, 6);
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, a, d);
      #1;
      n_cmp++;
      if ({tone_out, mix_out, tick} !== {exp_tone(), MIX_W'(m_mix), exp_tick()}) begin
        n_bad++;
        $display("FAIL random cyc=%0d: tone=%b mix=%0d tick=%b, expected tone=%b mix=%0d tick=%b",
                 i, tone_out, mix_out, tick, exp_tone(), m_mix, exp_tick());
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tone_out, mix_out, tick} !== '0) begin
      n_bad++;
      $display("FAIL midrun_reset: tone=%b mix=%0d tick=%b, expected all 0", tone_out, mix_out, tick);
    end
    @(negedge clk);
    ena = 1'b0; wr_en = 1'b0;
    rst_n = 1'b1;
  endtask

`ifdef PSG_TONE_BANK_NOISE_EN
  task automatic test_noise();
    do_reset();
    drive(1'b0, 1'b1, 3*NUM_CH+1, 1); drive(1'b0, 1'b1, 3*NUM_CH+2, 1);
    drive(1'b0, 1'b1, 3*NUM_CH, 0);   drive(1'b0, 1'b1, 2*NUM_CH, 8);
    for (int i = 0; i < 64*PRESCALE + 40; i++) begin
      drive(1'b1, 1'b0, 0, 0);
      #1;
      n_cmp++;
      if ({tone_out, mix_out, tick} !== {exp_tone(), MIX_W'(m_mix), exp_tick()}) begin
        n_bad++;
        $display("FAIL noise cyc=%0d: tone=%b mix=%0d tick=%b, expected tone=%b mix=%0d tick=%b lfsr=%05h",
                 i, tone_out, mix_out, tick, exp_tone(), m_mix, exp_tick(), m_lfsr);
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; ena = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    test_reset();
    test_period1();
    test_ch1_period5();
    test_full_mix_freeze();
    test_period_lower();
    test_random();
`ifdef PSG_TONE_BANK_NOISE_EN
    test_noise();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
